// File: rtl/nice_result_pkg.sv
// Shared encodings for the NICE result-response block: command functs,
// response bit positions, result width and FSM states.
package nice_result_pkg;

  localparam int RESULT_W    = 5;
  localparam int RSP_VLD_BIT = 8;
  localparam int RSP_OVF_BIT = 31;
  localparam int STATS_W     = 16;

  typedef enum logic [1:0] {
    FUNCT_POP   = 2'b00,
    FUNCT_COUNT = 2'b01,
    FUNCT_CLEAR = 2'b10,
    FUNCT_STATS = 2'b11
  } funct_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RSP  = 1'b1
  } state_e;

endpackage

// File: rtl/result_fifo.sv
// Synchronous DEPTH x RESULT_W result FIFO with clear, full/empty and occupancy.
// Reads are show-ahead: rd_data is the oldest entry whenever not empty.
module result_fifo
  import nice_result_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [RESULT_W-1:0]        wr_data,
  input  logic                       rd_en,
  input  logic                       clear,
  output logic [RESULT_W-1:0]        rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [RESULT_W-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic                do_wr;
  logic                do_rd;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign rd_data = mem[rd_ptr];

  // A full FIFO still takes a write when the same cycle frees a slot.
  assign do_rd = rd_en & ~empty & ~clear;
  assign do_wr = wr_en & ~clear & (~full | do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nice_result_rsp.sv
// NICE command front-end over the result FIFO: POP/COUNT/CLEAR/STATS with a
// one-cycle registered response. Optional counter under NICE_RESULT_STATS_EN.
module nice_result_rsp
  import nice_result_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int RSP_DW = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [RESULT_W-1:0] i_result_data,
  input  logic                i_result_data_valid,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [1:0]          i_cmd_funct,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [RSP_DW-1:0]   o_rsp_data,
  output logic                o_rsp_err,
  output logic                o_fifo_empty,
  output logic                o_fifo_full
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_e              state;
  funct_e              funct;
  logic                cmd_fire;
  logic                pop;
  logic                clr;
  logic                overflow;
  logic                ovf_set;
  logic [RESULT_W-1:0] fifo_rd_data;
  logic [CNT_W-1:0]    fifo_count;
  logic [RSP_DW-1:0]   rsp_data_nxt;
  logic                rsp_err_nxt;

  assign funct    = funct_e'(i_cmd_funct);
  assign cmd_fire = i_cmd_valid & o_cmd_ready;
  assign pop      = cmd_fire & (funct == FUNCT_POP);
  assign clr      = cmd_fire & (funct == FUNCT_CLEAR);

  // Only a genuinely dropped write counts as overflow; CLEAR-dropped writes do not.
  assign ovf_set  = i_result_data_valid & o_fifo_full & ~pop & ~clr;

  result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .wr_en   (i_result_data_valid),
    .wr_data (i_result_data),
    .rd_en   (pop),
    .clear   (clr),
    .rd_data (fifo_rd_data),
    .full    (o_fifo_full),
    .empty   (o_fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        overflow <= 1'b0;
    else if (clr)     overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
  end

`ifdef NICE_RESULT_STATS_EN
  logic [STATS_W-1:0] stats_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      stats_cnt <= '0;
    else if (clr)
      stats_cnt <= '0;
    else if (i_result_data_valid && (stats_cnt != '1))
      stats_cnt <= stats_cnt + STATS_W'(1);
  end
`endif

  always_comb begin
    rsp_data_nxt = '0;
    rsp_err_nxt  = 1'b0;
    case (funct)
      FUNCT_POP: begin
        if (o_fifo_empty) begin
          rsp_err_nxt = 1'b1;
        end else begin
          rsp_data_nxt[RESULT_W-1:0] = fifo_rd_data;
          rsp_data_nxt[RSP_VLD_BIT]  = 1'b1;
          rsp_data_nxt[RSP_OVF_BIT]  = overflow;
        end
      end
      FUNCT_COUNT: begin
        rsp_data_nxt[CNT_W-1:0]   = fifo_count;
        rsp_data_nxt[RSP_OVF_BIT] = overflow;
      end
      FUNCT_STATS: begin
`ifdef NICE_RESULT_STATS_EN
        rsp_data_nxt[STATS_W-1:0] = stats_cnt;
`else
        rsp_err_nxt = 1'b1;
`endif
      end
      default: begin
        rsp_data_nxt = '0;
        rsp_err_nxt  = 1'b0;
      end
    endcase
  end

  // Response payload is captured at accept and held untouched until the next accept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      o_cmd_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            state       <= ST_RSP;
            o_cmd_ready <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_data  <= rsp_data_nxt;
            o_rsp_err   <= rsp_err_nxt;
          end
        end
        ST_RSP: begin
          if (i_rsp_ready) begin
            state       <= ST_IDLE;
            o_cmd_ready <= 1'b1;
            o_rsp_valid <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          o_cmd_ready <= 1'b1;
          o_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nice_result_rsp.sv
// Directed bench for nice_result_rsp (DEPTH=8, RSP_DW=32); inputs driven on
// the falling edge, outputs sampled on the falling edge after the active one.
module tb_nice_result_rsp;

  localparam logic [1:0] F_POP   = 2'b00;
  localparam logic [1:0] F_COUNT = 2'b01;
  localparam logic [1:0] F_CLEAR = 2'b10;
  localparam logic [1:0] F_STATS = 2'b11;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [4:0]  i_result_data = '0;
  logic        i_result_data_valid = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic [1:0]  i_cmd_funct = '0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b1;
  logic [31:0] o_rsp_data;
  logic        o_rsp_err;
  logic        o_fifo_empty;
  logic        o_fifo_full;

  int checks   = 0;
  int failures = 0;

  logic [31:0] d;
  logic        e;
  logic [31:0] held;

  nice_result_rsp #(.DEPTH(8), .RSP_DW(32)) dut (
    .i_clk               (i_clk),
    .i_rst               (i_rst),
    .i_result_data       (i_result_data),
    .i_result_data_valid (i_result_data_valid),
    .i_cmd_valid         (i_cmd_valid),
    .o_cmd_ready         (o_cmd_ready),
    .i_cmd_funct         (i_cmd_funct),
    .o_rsp_valid         (o_rsp_valid),
    .i_rsp_ready         (i_rsp_ready),
    .o_rsp_data          (o_rsp_data),
    .o_rsp_err           (o_rsp_err),
    .o_fifo_empty        (o_fifo_empty),
    .o_fifo_full         (o_fifo_full)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s: observed=%h required=%h", tag, obs, req);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (o_cmd_ready !== 1'b1 && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    if (o_cmd_ready !== 1'b1) check("cmd_ready_timeout", {31'd0, o_cmd_ready}, 32'd1);
  endtask

  task automatic write_result(input logic [4:0] v);
    @(negedge i_clk);
    i_result_data       = v;
    i_result_data_valid = 1'b1;
    @(negedge i_clk);
    i_result_data_valid = 1'b0;
  endtask

  // Issue one command with rsp_ready high, optionally with a same-cycle write.
  task automatic cmd(input logic [1:0] f, input logic wr, input logic [4:0] wd,
                     output logic [31:0] rd, output logic re);
    int n = 0;
    wait_ready();
    i_cmd_valid         = 1'b1;
    i_cmd_funct         = f;
    i_rsp_ready         = 1'b1;
    i_result_data       = wd;
    i_result_data_valid = wr;
    @(negedge i_clk);
    i_cmd_valid         = 1'b0;
    i_result_data_valid = 1'b0;
    while (o_rsp_valid !== 1'b1 && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    if (o_rsp_valid !== 1'b1) check("rsp_valid_timeout", {31'd0, o_rsp_valid}, 32'd1);
    rd = o_rsp_data;
    re = o_rsp_err;
    @(negedge i_clk);
  endtask

  initial begin
    // Reset state, checked while reset is still asserted.
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    check("rst_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    check("rst_rsp_data", o_rsp_data, 32'd0);
    check("rst_rsp_err", {31'd0, o_rsp_err}, 32'd0);
    check("rst_empty", {31'd0, o_fifo_empty}, 32'd1);
    check("rst_full", {31'd0, o_fifo_full}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);

    // Basic write then pop ordering.
    write_result(5'd3);
    write_result(5'd7);
    write_result(5'd9);
    cmd(F_POP, 1'b0, 5'd0, d, e);
    check("pop0_data", d, 32'h103);
    check("pop0_err", {31'd0, e}, 32'd0);
    cmd(F_POP, 1'b0, 5'd0, d, e);
    check("pop1_data", d, 32'h107);
    cmd(F_POP, 1'b0, 5'd0, d, e);
    check("pop2_data", d, 32'h109);
    check("pop2_err", {31'd0, e}, 32'd0);
    check("empty_after_pops", {31'd0, o_fifo_empty}, 32'd1);

    // Pop while empty with a same-cycle write: error now, data next time.
    cmd(F_POP, 1'b1, 5'd5, d, e);
    check("empty_pop_err", {31'd0, e}, 32'd1);
    check("empty_pop_data", d, 32'd0);
    cmd(F_POP, 1'b0, 5'd0, d, e);
    check("late_pop_data", d, 32'h105);

    // Nine writes into eight slots: the ninth overflows.
    for (int i = 0; i < 9; i++) write_result(5'(10 + i));
    check("full_after_9", {31'd0, o_fifo_full}, 32'd1);
    cmd(F_COUNT, 1'b0, 5'd0, d, e);
    check("count_overflow", d, 32'h8000_0008);
    for (int i = 0; i < 8; i++) begin
      cmd(F_POP, 1'b0, 5'd0, d, e);
      check($sformatf("ovf_pop%0d", i), d, 32'h8000_0100 | 32'(10 + i));
    end
    check("empty_after_drain", {31'd0, o_fifo_empty}, 32'd1);
    cmd(F_CLEAR, 1'b0, 5'd0, d, e);
    check("clear_data", d, 32'd0);
    check("clear_err", {31'd0, e}, 32'd0);
    cmd(F_COUNT, 1'b0, 5'd0, d, e);
    check("count_after_clear", d, 32'd0);

    // Full FIFO: write and pop in one cycle.
    for (int i = 1; i <= 8; i++) write_result(5'(i));
    cmd(F_POP, 1'b1, 5'd20, d, e);
    check("full_wrpop_data", d, 32'h101);
    cmd(F_COUNT, 1'b0, 5'd0, d, e);
    check("full_wrpop_count", d, 32'd8);

    // Backpressure: response held for 4 cycles, command ignored meanwhile.
    wait_ready();
    i_cmd_valid = 1'b1;
    i_cmd_funct = F_POP;
    i_rsp_ready = 1'b0;
    @(negedge i_clk);
    i_cmd_funct = F_CLEAR;
    held = o_rsp_data;
    check("bp_first_data", held, 32'h102);
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      check($sformatf("bp_data%0d", i), o_rsp_data, 32'h102);
      check($sformatf("bp_ready%0d", i), {31'd0, o_cmd_ready}, 32'd0);
      check($sformatf("bp_valid%0d", i), {31'd0, o_rsp_valid}, 32'd1);
    end
    i_cmd_valid = 1'b0;
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    check("bp_released", {31'd0, o_rsp_valid}, 32'd0);
    cmd(F_COUNT, 1'b0, 5'd0, d, e);
    check("bp_count", d, 32'd7);

    // CLEAR with a same-cycle write drops the write without overflow.
    cmd(F_CLEAR, 1'b1, 5'd9, d, e);
    cmd(F_COUNT, 1'b0, 5'd0, d, e);
    check("clear_wr_count", d, 32'd0);

    // Reset in the middle of a pending response.
    write_result(5'd4);
    wait_ready();
    i_cmd_valid = 1'b1;
    i_cmd_funct = F_POP;
    i_rsp_ready = 1'b0;
    @(negedge i_clk);
    i_cmd_valid = 1'b0;
    check("midrst_pending", {31'd0, o_rsp_valid}, 32'd1);
    #2 i_rst = 1'b1;
    #1;
    check("midrst_valid", {31'd0, o_rsp_valid}, 32'd0);
    check("midrst_data", o_rsp_data, 32'd0);
    check("midrst_ready", {31'd0, o_cmd_ready}, 32'd1);
    check("midrst_empty", {31'd0, o_fifo_empty}, 32'd1);
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    check("postrst_valid", {31'd0, o_rsp_valid}, 32'd0);
    i_rsp_ready = 1'b1;

    // STATS after 20 writes.
    cmd(F_CLEAR, 1'b0, 5'd0, d, e);
    for (int i = 0; i < 20; i++) write_result(5'(i));
    cmd(F_STATS, 1'b0, 5'd0, d, e);
`ifdef NICE_RESULT_STATS_EN
    check("stats_data", d, 32'h14);
    check("stats_err", {31'd0, e}, 32'd0);
`else
    check("stats_data", d, 32'd0);
    check("stats_err", {31'd0, e}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
